// File: rtl/redundant_l3_normalizer_pkg.sv
// Shared BN254 field parameters and types (package PARAMS_BN254_d0),
// plus the widths and FSM state type used by redundant_l3_normalizer.
package PARAMS_BN254_d0;

   localparam int ADD_DIV = 4;

   typedef logic [255:0] uint_fp_t;
   typedef logic [63:0]  fp_div4_t;

   localparam uint_fp_t Mod =
      256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

   // One redundant limb: plain value plus a signed 8-bit carry that belongs
   // to the next limb position up.
   typedef struct packed {
      logic [7:0] carry;
      fp_div4_t   val;
   } redundant_limb_t;

   typedef redundant_limb_t [ADD_DIV-1:0] redundant_poly_L3;

   localparam int LIMB_W = $bits(fp_div4_t);
   localparam int FP_W   = $bits(uint_fp_t);
   localparam int NORM_W = FP_W + 10;

   // Modulus zero-extended to the signed working width of the normalizer.
   localparam logic [NORM_W-1:0] MOD_NORM = {{(NORM_W-FP_W){1'b0}}, Mod};

   typedef enum logic [1:0] {
      IDLE,
      PROP,
      REDUCE,
      DONE
   } norm_state_t;

endpackage

// File: rtl/redundant_l3_normalizer_cond_addsub.sv
// fp_cond_addsub: one conditional +p / -p / +0 correction step on a
// NORM_W-bit two's-complement value. All three cases share a single adder.
module fp_cond_addsub
   import PARAMS_BN254_d0::*;
(
   input  logic [NORM_W-1:0] v,
   input  logic [NORM_W-1:0] p,
   output logic [NORM_W-1:0] v_next,
   output logic              in_range,
   output logic              step_taken
);

   logic [NORM_W-1:0] addend;

   // Select the addend from the sign of v and its relation to p.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      addend     = '0;
      in_range   = 1'b0;
      step_taken = 1'b1;
      if (v[NORM_W-1]) begin
         addend = p;
      end else if (v >= p) begin
         addend = ~p + 1'b1;
      end else begin
         in_range   = 1'b1;
         step_taken = 1'b0;
      end
      v_next = v + addend;
   end

endmodule

// File: rtl/redundant_l3_normalizer.sv
// redundant_l3_normalizer: resolves the per-limb carries of a
// redundant_poly_L3 operand one limb per cycle, then brings the result into
// [0, p) with up to MAX_RED +/-p steps.
// Optional build macro NORM_CONST_TIME_EN: fixed-length reduction phase
// (MAX_RED correction cycles plus the final decision cycle) so latency does
// not depend on the operand.
module redundant_l3_normalizer
   import PARAMS_BN254_d0::*;
#(
   parameter int MAX_RED = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  redundant_poly_L3 din,
   output logic             out_valid,
   input  logic             out_ready,
   output uint_fp_t         dout,
   output logic             out_err,
   output logic             busy
);

   localparam int              K_W     = (ADD_DIV > 1) ? $clog2(ADD_DIV) : 1;
   localparam logic [K_W-1:0]  K_LAST  = K_W'(ADD_DIV - 1);
   localparam logic [3:0]      CNT_MAX = 4'(MAX_RED);

   norm_state_t       state;
   norm_state_t       state_next;
   redundant_poly_L3  din_q;
   logic [K_W-1:0]    k;
   logic [9:0]        c_q;
   logic [NORM_W-1:0] v_q;
   logic [3:0]        cnt;

   fp_div4_t          cur_val;
   logic [7:0]        prev_carry;
   logic [7:0]        last_carry;
   logic [LIMB_W+9:0] prop_sum;
   logic [9:0]        c_next;
   logic [9:0]        top_bits;

   logic [NORM_W-1:0] v_next;
   logic              in_range;
   logic              step_taken;
   logic              reduce_done;
   logic              reduce_err;

   // Carry propagation for limb k: val_k + carry_{k-1} + running carry,
   // all sign-extended to a common width; the high bits are the new carry.
   always_comb begin
      cur_val    = din_q[k].val;
      prev_carry = '0;
      if (k != '0) prev_carry = din_q[k - 1'b1].carry;
      last_carry = din_q[ADD_DIV-1].carry;
      prop_sum   = {10'b0, cur_val}
                 + {{(LIMB_W+2){prev_carry[7]}}, prev_carry}
                 + {{LIMB_W{c_q[9]}}, c_q};
      c_next     = prop_sum[LIMB_W+9:LIMB_W];
      top_bits   = c_next + {{2{last_carry[7]}}, last_carry};
   end

   fp_cond_addsub u_addsub (
      .v          (v_q),
      .p          (MOD_NORM),
      .v_next     (v_next),
      .in_range   (in_range),
      .step_taken (step_taken)
   );

   // Decide when the reduction phase ends and whether it failed to converge.
   always_comb begin
`ifdef NORM_CONST_TIME_EN
      reduce_done = (cnt == CNT_MAX);
      reduce_err  = !in_range;
`else
      reduce_done = in_range || (cnt == CNT_MAX);
      reduce_err  = step_taken;
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid && in_ready) state_next = PROP;
         PROP:    if (k == K_LAST)          state_next = REDUCE;
         REDUCE:  if (reduce_done)          state_next = DONE;
         DONE:    if (out_ready)            state_next = IDLE;
         default:                           state_next = IDLE;
      endcase
   end

   // Handshake and status outputs, decoded from state.
   always_comb begin
      in_ready  = (state == IDLE) && !rst;
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Datapath: operand capture, limb-serial carry resolution, reduction.
   always_ff @(posedge clk) begin
      // NOTE: the datapath registers are reset too, so dout/out_err read 0 and
      // a dropped transaction leaves nothing behind.
      if (rst) begin
         din_q   <= '0;
         k       <= '0;
         c_q     <= '0;
         v_q     <= '0;
         cnt     <= '0;
         dout    <= '0;
         out_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  din_q <= din;
                  k     <= '0;
                  c_q   <= '0;
                  cnt   <= '0;
               end
            end
            PROP: begin
               v_q[k*LIMB_W +: LIMB_W] <= prop_sum[LIMB_W-1:0];
               c_q                     <= c_next;
               k                       <= k + 1'b1;
               if (k == K_LAST) v_q[NORM_W-1:FP_W] <= top_bits;
            end
            REDUCE: begin
               if (reduce_done) begin
                  dout    <= v_q[FP_W-1:0];
                  out_err <= reduce_err;
               end else begin
                  v_q <= v_next;
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_redundant_l3_normalizer.sv
// Directed bench for redundant_l3_normalizer. A second instance with
// MAX_RED=2 covers the non-convergence case. Build macro
// NORM_CONST_TIME_EN changes only the expected latencies.
module tb_redundant_l3_normalizer;
   import PARAMS_BN254_d0::*;

   localparam int MR  = 8;
   localparam int MR2 = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_valid2;
   logic             out_ready;
   logic             out_ready2;
   redundant_poly_L3 din;
   logic             in_ready, out_valid, out_err, busy;
   logic             in_ready2, out_valid2, out_err2, busy2;
   uint_fp_t         dout, dout2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   redundant_l3_normalizer #(.MAX_RED(MR)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .out_err   (out_err),
      .busy      (busy)
   );

   redundant_l3_normalizer #(.MAX_RED(MR2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .din       (din),
      .out_valid (out_valid2),
      .out_ready (out_ready2),
      .dout      (dout2),
      .out_err   (out_err2),
      .busy      (busy2)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic redundant_poly_L3 pack_vals(input uint_fp_t x);
      redundant_poly_L3 d;
      d = '0;
      for (int i = 0; i < ADD_DIV; i++) d[i].val = x[i*LIMB_W +: LIMB_W];
      return d;
   endfunction

   // Expected cycles from accept edge to out_valid for r correction steps.
   function automatic int exp_lat(input int r);
`ifdef NORM_CONST_TIME_EN
      return ADD_DIV + 1 + MR;
`else
      return ADD_DIV + 1 + r;
`endif
   endfunction

   // Wait (bounded) for out_valid on the main instance; returns cycles waited.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Full transaction on the main instance with immediate handshake.
   task automatic run_txn(input string tag, input redundant_poly_L3 d,
                          input uint_fp_t exp_dout, input logic exp_err, input int lat_exp);
      int lat;
      @(negedge clk);
      check({tag, " in_ready"}, 256'(in_ready), 256'(1));
      din      = d;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(lat);
      check({tag, " latency"}, 256'(lat), 256'(lat_exp));
      check({tag, " dout"}, dout, exp_dout);
      check({tag, " out_err"}, 256'(out_err), 256'(exp_err));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " out_valid cleared"}, 256'(out_valid), 256'(0));
      check({tag, " idle again"}, 256'(busy), 256'(0));
   endtask

   initial begin
      redundant_poly_L3 d;
      uint_fp_t         five_p;
      uint_fp_t         three_p;
      int               lat;
      logic             seen;

      rst        = 1'b1;
      in_valid   = 1'b0;
      in_valid2  = 1'b0;
      out_ready  = 1'b0;
      out_ready2 = 1'b0;
      din        = '0;
      five_p     = Mod * 256'd5;
      three_p    = Mod * 256'd3;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst in_ready", 256'(in_ready), 256'(0));
      check("rst out_valid", 256'(out_valid), 256'(0));
      check("rst dout", dout, 256'(0));
      check("rst out_err", 256'(out_err), 256'(0));
      check("rst busy", 256'(busy), 256'(0));
      check("rst in_ready2", 256'(in_ready2), 256'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post-rst in_ready", 256'(in_ready), 256'(1));

      // Directed vectors.
      run_txn("zero", '0, '0, 1'b0, exp_lat(0));

      d = '0; d[0].val = '1; d[0].carry = 8'h01;
      run_txn("ripple", d, (256'd1 << 65) - 256'd1, 1'b0, exp_lat(0));

      run_txn("eq_mod", pack_vals(Mod), '0, 1'b0, exp_lat(1));
      run_txn("mod_m1", pack_vals(Mod - 256'd1), Mod - 256'd1, 1'b0, exp_lat(0));

      d = '0; d[0].carry = 8'hFF;
      run_txn("neg_limb", d, Mod - (256'd1 << 64), 1'b0, exp_lat(1));

      d = '0; d[2].carry = 8'h02;
      run_txn("mid_carry", d, 256'd1 << 193, 1'b0, exp_lat(0));

      run_txn("five_p_mr8", pack_vals(five_p), '0, 1'b0, exp_lat(5));

      // Non-convergence on the MAX_RED=2 instance: 5p -> 4p -> 3p, then error.
      @(negedge clk);
      check("mr2 in_ready", 256'(in_ready2), 256'(1));
      din       = pack_vals(five_p);
      in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      lat = 0;
      while (!out_valid2 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check("mr2 latency", 256'(lat), 256'(ADD_DIV + 1 + MR2));
      check("mr2 out_err", 256'(out_err2), 256'(1));
      check("mr2 dout", dout2, three_p);
      check("mr2 main untouched", 256'(busy), 256'(0));
      @(negedge clk);
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0;
      check("mr2 out_valid cleared", 256'(out_valid2), 256'(0));

      // Back-pressure: hold DONE for 10 cycles while in_valid is asserted
      // with a different operand, which must be ignored.
      @(negedge clk);
      din      = pack_vals(Mod + 256'd5);
      in_valid = 1'b1;
      @(posedge clk); #1;
      din = pack_vals(Mod - 256'd1);
      wait_valid(lat);
      check("hold latency", 256'(lat), 256'(exp_lat(1)));
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("hold dout", dout, 256'd5);
         check("hold out_err", 256'(out_err), 256'(0));
         check("hold in_ready", 256'(in_ready), 256'(0));
         check("hold out_valid", 256'(out_valid), 256'(1));
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("hold release", 256'(out_valid), 256'(0));
      check("hold no new accept", 256'(busy), 256'(0));

      // Reset during PROP drops the operand.
      @(negedge clk);
      din      = pack_vals(Mod + 256'd5);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("midrst busy before", 256'(busy), 256'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst in_ready", 256'(in_ready), 256'(1));
      check("midrst busy", 256'(busy), 256'(0));
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("midrst no output", 256'(seen), 256'(0));

      // Recovery after the dropped transaction.
      run_txn("after_rst", pack_vals(Mod + 256'd7), 256'd7, 1'b0, exp_lat(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
